// File: rtl/instr_queue_if.sv
// rtl/instr_queue_if.sv - upstream enqueue, downstream dequeue and status signals of instr_queue
interface instr_queue_if #(
  parameter int DEPTH  = 8,
  parameter int CW_W   = 160,
  parameter int RVFI_W = 224
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              ld_iq;
  logic [CW_W-1:0]   cw_in;
  logic [RVFI_W-1:0] rvfi_in;
  logic              iq_ack;
  logic              flush_ip;
  logic              deq_ready;
  logic              deq_valid;
  logic [CW_W-1:0]   cw_out;
  logic [RVFI_W-1:0] rvfi_out;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  modport master (
    output ld_iq, cw_in, rvfi_in, flush_ip, deq_ready,
    input  iq_ack, deq_valid, cw_out, rvfi_out, count, full, empty
  );

  modport slave (
    input  ld_iq, cw_in, rvfi_in, flush_ip, deq_ready,
    output iq_ack, deq_valid, cw_out, rvfi_out, count, full, empty
  );
endinterface

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - in-order instruction FIFO between fetch and dispatch with mispredict flush
module instr_queue #(
  parameter int DEPTH  = 8,
  parameter int CW_W   = 160,
  parameter int RVFI_W = 224
) (
  input  logic          clk,
  input  logic          rst,
  instr_queue_if.slave  q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CW_W-1:0]   cw_mem   [DEPTH];
  logic [RVFI_W-1:0] rvfi_mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              deq;
  logic              ack;
  logic              enq;

  // During a flush every request is acked and dropped so upstream never stalls on a dead queue.
  always_comb begin
    empty = (count == '0);
    full  = (count == CNT_W'(DEPTH));
    deq   = !empty && q.deq_ready && !q.flush_ip;
    ack   = q.ld_iq && (q.flush_ip || !full || deq);
    enq   = ack && !q.flush_ip;
  end

  assign q.iq_ack    = ack;
  assign q.deq_valid = !empty;
  assign q.cw_out    = empty ? '0 : cw_mem[head];
  assign q.rvfi_out  = empty ? '0 : rvfi_mem[head];
  assign q.count     = count;
  assign q.full      = full;
  assign q.empty     = empty;

  always_ff @(posedge clk) begin
    if (enq) begin
      cw_mem[tail]   <= q.cw_in;
      rvfi_mem[tail] <= q.rvfi_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (q.flush_ip) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (deq) head <= head + PTR_W'(1);
      if (enq) tail <= tail + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- FIFO between the instruction register/fetch stage (upstream) and the dispatch/reservation-station stage (downstream) of the Tomasulo core.
- Buffers decoded control words with their rvfi debug words, in program order.
- Upstream handshake: ld_iq / iq_ack. Downstream handshake: valid/ready.
- A branch-mispredict flush discards all buffered entries.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- CW_W, 160, width of the flattened tomasula control word.
- RVFI_W, 224, width of the flattened rvfi word.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- ld_iq  in  1  upstream requests enqueue of cw_in/rvfi_in; may be held for several cycles until acknowledged.
- cw_in  in  CW_W  control word to enqueue.
- rvfi_in  in  RVFI_W  rvfi word to enqueue.
- iq_ack  out  1  combinational; enqueue accepted at this rising edge.
- flush_ip  in  1  mispredict flush in progress.
- deq_ready  in  1  dispatch consumes the head entry this cycle.
- deq_valid  out  1  head entry is valid.
- cw_out  out  CW_W  head control word.
- rvfi_out  out  RVFI_W  head rvfi word.
- count  out  $clog2(DEPTH+1)  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- State: entry storage array (not reset), head pointer, tail pointer, count register. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Reset (rst==0, asynchronous): head=0, tail=0, count=0. Outputs: empty=1, full=0, deq_valid=0, cw_out=0, rvfi_out=0, iq_ack=0 whenever ld_iq=0.
- deq_valid = !empty.
- cw_out/rvfi_out = entry[head] when !empty; forced to 0 when empty. No bypass from cw_in to the outputs, so enqueue-to-visible latency is 1 cycle.
- deq = deq_valid & deq_ready & !flush_ip. On deq: head+=1.
- iq_ack, normal case (flush_ip=0): iq_ack = ld_iq & (!full | deq).
  - Full with a dequeue in the same cycle is accepted: the write and read occur on the same edge and count is unchanged.
- enq = iq_ack & !flush_ip. On enq: entry[tail] <= {cw_in, rvfi_in}; tail+=1.
- count update: +1 on enq only; -1 on deq only; unchanged on both or neither. count never exceeds DEPTH and never underflows.
- Empty with simultaneous enq: the entry is written, and deq_valid rises in the next cycle. No same-cycle pass-through.
- Flush (flush_ip=1, checked every cycle):
  - At the next edge: head=0, tail=0, count=0.
  - iq_ack = ld_iq regardless of full. The request is acknowledged but discarded, so upstream cannot deadlock while stalled during a flush.
  - deq is suppressed.
  - Flush held for multiple cycles: the queue stays empty, and every ld_iq is acked and dropped.
  - Flush has priority over enq and deq.
- Reset mid-operation clears pointers and count immediately (asynchronous). Storage contents are don't-care afterwards.
- ld_iq=0: no enqueue, iq_ack=0. cw_in is ignored.
- deq_ready while empty: no effect.
- Assertions for the bench: no enq when full & !deq & !flush_ip; count == (tail-head) mod DEPTH, or DEPTH when full.

Test Plan:
- Reset then idle: rst low 2 cycles, release → empty=1, full=0, count=0, deq_valid=0, cw_out=0; ld_iq=1 with cw_in=A, deq_ready=0 → iq_ack=1 that cycle; next cycle deq_valid=1, cw_out=A, count=1.
- Fill and order: enqueue A0..A7 back-to-back (DEPTH=8, deq_ready=0) → iq_ack high for all 8, full=1, count=8. A ninth ld_iq holds with iq_ack=0. Then deq_ready=1 for 8 cycles → cw_out sequence A0..A7, empty=1 at the end.
- Full with simultaneous enq/deq: at full, ld_iq=1 (B) and deq_ready=1 → iq_ack=1, A0 leaves, count stays 8; after draining, B is the last entry out.
- Wrap-around: 20 enqueues interleaved with dequeues, occupancy kept at 3 → pointers wrap twice, output order matches input, count=3 throughout the steady state.
- Flush: 5 entries queued, flush_ip=1 for 2 cycles with ld_iq=1 (C) → iq_ack=1 both cycles, count=0 and empty=1 after the first edge, no deq occurs, C is never output. After flush_ip=0, enqueue D → D is the first output.
- Async reset mid-operation: count=4, drop rst between clock edges → count=0, deq_valid=0 immediately, before the next clk edge.
